// File: rtl/x_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : x_buffer_ctrl
//  Purpose  : Sequencer for the four-slot X row buffer of the 3x3
//             convolution datapath. Preloads image rows 0..2 into slots
//             1..3. For each output row it then issues ALU beats while
//             loading the next image row into the free slot. Each row ends
//             with a rotate pulse, and a done pulse follows the last row.
//  Ports    : clk, rst         - clock / async active-high reset
//             start            - run request (sampled in IDLE only)
//             in_valid/in_ready- word source handshake (in_ready == load_en)
//             load_done        - X buffer reports a full row loaded
//             alu_ready        - MAC array accepts a beat
//             load_en, alu_en  - X buffer load enable / shift beat
//             row_finish       - one-cycle row-end rotate pulse
//             row_count        - row index driving slot selection
//             busy, done       - activity flag / one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module x_buffer_ctrl #(
    parameter int N_ROWS     = 28,
    parameter int ALU_STEPS  = 27,
    parameter int LOAD_WORDS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       load_done,
    input  logic       alu_ready,
    output logic       load_en,
    output logic       alu_en,
    output logic       row_finish,
    output logic [4:0] row_count,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] c_LOAD_WORDS    = 3'(LOAD_WORDS);
    localparam logic [4:0] c_ALU_STEPS     = 5'(ALU_STEPS);
    // Last output row, and last output row that still has an image row to fetch.
    localparam logic [4:0] c_LAST_ROW      = 5'(N_ROWS - 3);
    localparam logic [4:0] c_LAST_LOAD_ROW = 5'(N_ROWS - 4);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_COMPUTE = 3'd2,
        S_ROW_END = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     r_state,     w_state_nxt;
    logic [2:0] r_word_cnt,  w_word_cnt_nxt;
    logic [4:0] r_step_cnt,  w_step_cnt_nxt;
    logic [4:0] r_row_count, w_row_count_nxt;
    logic       r_loaded,    w_loaded_nxt;
    logic [4:0] w_row_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_word_cnt  <= 3'd0;
            r_step_cnt  <= 5'd0;
            r_row_count <= 5'd0;
            r_loaded    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_row_count <= w_row_count_nxt;
            r_loaded    <= w_loaded_nxt;
        end
    end

    assign w_row_inc = r_row_count + 5'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_word_cnt_nxt  = r_word_cnt;
        w_step_cnt_nxt  = r_step_cnt;
        w_row_count_nxt = r_row_count;
        w_loaded_nxt    = r_loaded;
        load_en         = 1'b0;
        alu_en          = 1'b0;
        row_finish      = 1'b0;
        done            = 1'b0;
        busy            = 1'b1;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt     = S_PRELOAD;
                    w_row_count_nxt = 5'd1;
                    w_word_cnt_nxt  = 3'd0;
                    w_step_cnt_nxt  = 5'd0;
                    w_loaded_nxt    = 1'b0;
                end
            end

            S_PRELOAD: begin
                // Holding load_en low at a full row keeps the load_done cycle transfer-free.
                load_en = (r_word_cnt < c_LOAD_WORDS);
                if (load_en && in_valid) begin
                    w_word_cnt_nxt = r_word_cnt + 3'd1;
                end
                if (load_done) begin
                    w_word_cnt_nxt = 3'd0;
                    if (r_row_count == 5'd3) begin
                        w_state_nxt     = S_COMPUTE;
                        w_row_count_nxt = 5'd0;
                        w_step_cnt_nxt  = 5'd0;
                        w_loaded_nxt    = (5'd0 > c_LAST_LOAD_ROW);
                    end else begin
                        w_row_count_nxt = w_row_inc;
                    end
                end
            end

            S_COMPUTE: begin
                alu_en  = (r_step_cnt < c_ALU_STEPS) && alu_ready;
                load_en = !r_loaded && (r_word_cnt < c_LOAD_WORDS);
                if (alu_en) begin
                    w_step_cnt_nxt = r_step_cnt + 5'd1;
                end
                if (load_en && in_valid) begin
                    w_word_cnt_nxt = r_word_cnt + 3'd1;
                end
                if (load_done) begin
                    w_loaded_nxt = 1'b1;
                end
                // Look at the post-beat count so the final beat and the exit share a cycle,
                // giving a row period of ALU_STEPS beats plus one ROW_END cycle.
                if ((w_step_cnt_nxt == c_ALU_STEPS) && (r_loaded || load_done)) begin
                    w_state_nxt = S_ROW_END;
                end
            end

            S_ROW_END: begin
                row_finish = 1'b1;
                if (r_row_count == c_LAST_ROW) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt     = S_COMPUTE;
                    w_row_count_nxt = w_row_inc;
                    w_word_cnt_nxt  = 3'd0;
                    w_step_cnt_nxt  = 5'd0;
                    // The tail rows have no image row left to fetch.
                    w_loaded_nxt    = (w_row_inc > c_LAST_LOAD_ROW);
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready  = load_en;
    assign row_count = r_row_count;

endmodule
`default_nettype wire

// File: tb/tb_x_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x_buffer_ctrl
//  Purpose  : Self-checking bench for x_buffer_ctrl. An X buffer model
//             answers word transfers with load_done. A row/slot bookkeeping
//             model predicts every output each cycle. A vector table pins
//             the nominal timeline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_x_buffer_ctrl;

    localparam int N_ROWS     = 28;
    localparam int ALU_STEPS  = 27;
    localparam int LOAD_WORDS = 7;
    localparam int OUT_ROWS   = N_ROWS - 2;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_ready, load_done, alu_ready;
    logic       load_en, alu_en, row_finish, busy, done;
    logic [4:0] row_count;

    always #5 clk = ~clk;

    x_buffer_ctrl #(.N_ROWS(N_ROWS), .ALU_STEPS(ALU_STEPS), .LOAD_WORDS(LOAD_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .load_done(load_done), .alu_ready(alu_ready), .load_en(load_en), .alu_en(alu_en),
        .row_finish(row_finish), .row_count(row_count), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    // Model: k = image rows fully loaded, r = current output row, beats = ALU beats in row r.
    bit active, ld_pending, done_next;
    int k, r, beats, words, rc_hold;

    // Stimulus mode
    int p_valid, p_ready, hold_lo, hold_hi;
    bit junk_start, junk_ld;

    // Per-run statistics
    int n_xfer, n_alu, n_rf, done_cyc, first_rf_cyc, row_beats;
    int ld_q[$];
    logic [9:0] trace_cur [0:1023];
    logic [9:0] trace_ref [0:1023];

    typedef struct {
        int off; int ld; int alu; int rf; int bz; int dn; int rc;
    } vec_t;
    vec_t tbl [19];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        active = 0; ld_pending = 0; done_next = 0;
        k = 0; r = 0; beats = 0; words = 0; rc_hold = 0;
    endtask

    task automatic run(input int rst_at);
        int  cyc;
        bit  fin, fin_next, real_ld, ignorable;
        int  e_ld, e_alu, e_rf, e_bz, e_dn, e_rc;
        cyc = 0; fin = 0; fin_next = 0;
        n_xfer = 0; n_alu = 0; n_rf = 0; done_cyc = -1; first_rf_cyc = -1; row_beats = 0;
        ld_q.delete();
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            ignorable = !active || done_next ||
                        (k >= 3 && (k >= r + 4 || k == N_ROWS));
            real_ld   = ld_pending;
            start     = (cyc == 0) || (junk_start && active && $urandom_range(0, 9) == 0);
            in_valid  = !(cyc >= hold_lo && cyc < hold_hi) && ($urandom_range(0, 99) < p_valid);
            alu_ready = ($urandom_range(0, 99) < p_ready);
            load_done = real_ld || (junk_ld && ignorable && $urandom_range(0, 3) == 0);
            #1;
            // Prediction from slot bookkeeping
            e_ld = 0; e_alu = 0; e_rf = 0; e_dn = 0; e_bz = active; e_rc = rc_hold;
            if (active) begin
                if (done_next) begin
                    e_dn = 1;
                end else if (k < 3) begin
                    e_ld = !real_ld;
                    e_rc = k + 1;
                end else begin
                    e_rc  = r;
                    e_alu = alu_ready && (beats < ALU_STEPS);
                    e_rf  = (beats == ALU_STEPS) && (k >= r + 4 || k == N_ROWS);
                    e_ld  = !real_ld && (k < N_ROWS) && (k == r + 3);
                end
            end
            chk("load_en", load_en, e_ld);
            chk("in_ready", in_ready, e_ld);
            chk("alu_en", alu_en, e_alu);
            chk("row_finish", row_finish, e_rf);
            chk("busy", busy, e_bz);
            chk("done", done, e_dn);
            chk("row_count", row_count, e_rc);
            if (row_finish) begin
                chk("beats_per_row", row_beats, ALU_STEPS);
                row_beats = 0;
                if (first_rf_cyc < 0) first_rf_cyc = cyc;
            end
            row_beats += alu_en;
            if (cyc < 1024) trace_cur[cyc] = {load_en, alu_en, row_finish, busy, done, row_count};
            n_xfer += (in_valid && in_ready);
            n_alu  += alu_en;
            n_rf   += row_finish;
            if (done) done_cyc = cyc;
            if (fin_next) fin = 1;
            // Advance model
            if (real_ld) begin
                ld_q.push_back(cyc);
                k++;
                ld_pending = 0;
            end
            if (in_valid && in_ready) begin
                words++;
                if (words == LOAD_WORDS) begin
                    words = 0;
                    ld_pending = 1;
                end
            end
            if (active) begin
                if (done_next) begin
                    active = 0; done_next = 0; fin_next = 1;
                end else begin
                    beats += e_alu;
                    if (e_rf) begin
                        if (r == OUT_ROWS - 1) done_next = 1;
                        r++;
                        beats = 0;
                    end
                end
                rc_hold = e_rc;
            end else if (start) begin
                active = 1; k = 0; r = 0; beats = 0; words = 0; ld_pending = 0;
            end
            if (cyc == rst_at) begin
                rst = 1;
                #1;
                chk("rst_load_en", load_en, 0);
                chk("rst_alu_en", alu_en, 0);
                chk("rst_row_finish", row_finish, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_row_count", row_count, 0);
                model_reset();
                fin = 1;
            end
            cyc++;
        end
        if (!fin) chk("run_timeout", 0, 1);
        start = 0; in_valid = 0; load_done = 0; alu_ready = 0;
        if (rst) begin
            @(posedge clk);
            #1;
            chk("rst_hold_busy", busy, 0);
            @(negedge clk);
            rst = 0;
        end
    endtask

    task automatic set_mode(input int pv, input int pr, input int hl, input int hh,
                            input bit js, input bit jl);
        p_valid = pv; p_ready = pr; hold_lo = hl; hold_hi = hh;
        junk_start = js; junk_ld = jl;
    endtask

    initial begin
        int diff, stall_alu;
        tbl = '{
            '{  0, 0, 0, 0, 0, 0,  0}, '{  1, 1, 0, 0, 1, 0,  1}, '{  7, 1, 0, 0, 1, 0,  1},
            '{  8, 0, 0, 0, 1, 0,  1}, '{  9, 1, 0, 0, 1, 0,  2}, '{ 16, 0, 0, 0, 1, 0,  2},
            '{ 17, 1, 0, 0, 1, 0,  3}, '{ 24, 0, 0, 0, 1, 0,  3}, '{ 25, 1, 1, 0, 1, 0,  0},
            '{ 31, 1, 1, 0, 1, 0,  0}, '{ 32, 0, 1, 0, 1, 0,  0}, '{ 51, 0, 1, 0, 1, 0,  0},
            '{ 52, 0, 0, 1, 1, 0,  0}, '{ 53, 1, 1, 0, 1, 0,  1}, '{697, 1, 1, 0, 1, 0, 24},
            '{725, 0, 1, 0, 1, 0, 25}, '{752, 0, 0, 1, 1, 0, 25}, '{753, 0, 0, 0, 1, 1, 25},
            '{754, 0, 0, 0, 0, 0, 25}
        };
        rst = 1; start = 0; in_valid = 0; load_done = 0; alu_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_load_en", load_en, 0);
        chk("reset_alu_en", alu_en, 0);
        chk("reset_row_finish", row_finish, 0);
        chk("reset_row_count", row_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 0;

        // Nominal run with timeline table
        set_mode(100, 100, -1, -1, 0, 0);
        run(-1);
        chk("nominal_transfers", n_xfer, N_ROWS * LOAD_WORDS);
        chk("nominal_alu_beats", n_alu, OUT_ROWS * ALU_STEPS);
        chk("nominal_row_finish", n_rf, OUT_ROWS);
        chk("nominal_done_cycle", done_cyc, 753);
        for (int i = 0; i < 19; i++) begin
            chk($sformatf("tbl%0d_load_en", tbl[i].off), trace_cur[tbl[i].off][9], tbl[i].ld);
            chk($sformatf("tbl%0d_alu_en", tbl[i].off), trace_cur[tbl[i].off][8], tbl[i].alu);
            chk($sformatf("tbl%0d_row_finish", tbl[i].off), trace_cur[tbl[i].off][7], tbl[i].rf);
            chk($sformatf("tbl%0d_busy", tbl[i].off), trace_cur[tbl[i].off][6], tbl[i].bz);
            chk($sformatf("tbl%0d_done", tbl[i].off), trace_cur[tbl[i].off][5], tbl[i].dn);
            chk($sformatf("tbl%0d_row_count", tbl[i].off), trace_cur[tbl[i].off][4:0], tbl[i].rc);
        end
        for (int i = 0; i < 1024; i++) trace_ref[i] = trace_cur[i];

        // Back-pressure: no words for 40 cycles from the start of row 0
        set_mode(100, 100, 25, 65, 0, 0);
        run(-1);
        chk("bp_row0_load_done_cycle", (ld_q.size() > 3) ? ld_q[3] : -1, 72);
        chk("bp_row0_finish_cycle", first_rf_cyc, 73);
        stall_alu = 0;
        for (int i = 52; i < 73; i++) stall_alu += trace_cur[i][8];
        chk("bp_alu_during_hold", stall_alu, 0);
        chk("bp_alu_beats", n_alu, OUT_ROWS * ALU_STEPS);

        // alu_ready at 50%
        set_mode(100, 50, -1, -1, 0, 0);
        run(-1);
        chk("half_ready_alu_beats", n_alu, OUT_ROWS * ALU_STEPS);
        chk("half_ready_row_finish", n_rf, OUT_ROWS);

        // Random stalls plus ignored start / load_done pulses
        for (int j = 0; j < 2; j++) begin
            set_mode(60, 50, -1, -1, 1, 1);
            run(-1);
            chk("rand_transfers", n_xfer, N_ROWS * LOAD_WORDS);
            chk("rand_row_finish", n_rf, OUT_ROWS);
        end

        // Async reset mid-run, then a repeat of the nominal trace
        set_mode(100, 100, -1, -1, 0, 0);
        run(300);
        set_mode(100, 100, -1, -1, 1, 0);
        run(-1);
        diff = 0;
        for (int i = 0; i <= 754; i++) diff += (trace_cur[i] != trace_ref[i]);
        chk("repeat_trace_diff_cycles", diff, 0);
        chk("repeat_done_cycle", done_cyc, 753);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
